// File: rtl/cache_pkg.sv
// Shared definitions for the cache line refill engine: width helpers,
// FSM state encoding and the fixed AXI burst attributes.
package cache_pkg;

  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int LINE_WIDTH_DEF  = 6;
  localparam int CACHE_WIDTH_DEF = 6;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  function automatic int tag_width(input int aw, input int lw, input int cw);
    return aw - lw - cw;
  endfunction

  function automatic int index_width(input int lw);
    return lw - 2;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/cache_line_refill.sv
// Miss engine for one direct-mapped line: optional dirty write-back burst,
// then a count-terminated read burst written into the line store word by word.
module cache_line_refill
  import cache_pkg::*;
#(
  parameter  int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter  int LINE_WIDTH  = LINE_WIDTH_DEF,
  parameter  int CACHE_WIDTH = CACHE_WIDTH_DEF,
  localparam int TAG_WIDTH   = tag_width(ADDR_WIDTH, LINE_WIDTH, CACHE_WIDTH),
  localparam int IDX_W       = index_width(LINE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss_req,
  input  logic [ADDR_WIDTH-1:0] i_miss_addr,
  input  logic                  i_victim_valid,
  input  logic                  i_victim_dirty,
  input  logic [TAG_WIDTH-1:0]  i_victim_tag,
  input  logic [31:0]           i_victim_data,
  output logic                  o_line_write_en,
  output logic                  o_line_valid,
  output logic                  o_line_dirty,
  output logic [TAG_WIDTH-1:0]  o_line_tag,
  output logic [IDX_W-1:0]      o_line_index,
  output logic [31:0]           o_line_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic [7:0]            o_awlen,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [31:0]           o_wdata,
  output logic                  o_wlast,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  input  logic [31:0]           i_rdata,
  input  logic                  i_rlast,
  input  logic                  i_rvalid,
  output logic                  o_rready
);

  localparam int         WORDS = 1 << IDX_W;
  localparam logic [7:0] LEN   = 8'(WORDS - 1);

  state_t                r_state, w_next;
  logic [IDX_W-1:0]      r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [TAG_WIDTH-1:0]  r_vtag;

  logic [CACHE_WIDTH-1:0] w_set;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic                   w_last;
  logic                   w_unused;

  assign w_set  = r_addr[LINE_WIDTH+CACHE_WIDTH-1:LINE_WIDTH];
  assign w_tag  = r_addr[ADDR_WIDTH-1:LINE_WIDTH+CACHE_WIDTH];
  assign w_last = (r_cnt == IDX_W'(WORDS - 1));
  assign o_busy = (r_state != S_IDLE);
  // rlast is deliberately ignored: the burst ends on the beat count alone.
  assign w_unused = ^{i_rlast, r_addr[LINE_WIDTH-1:0], BURST_INCR, SIZE_4B};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_vtag  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && i_miss_req) begin
        r_addr <= i_miss_addr;
        r_vtag <= i_victim_tag;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_cnt_next      = r_cnt;
    o_line_write_en = 1'b0;
    o_line_valid    = 1'b0;
    o_line_dirty    = 1'b0;
    o_line_tag      = '0;
    o_line_index    = '0;
    o_line_wdata    = '0;
    o_done          = 1'b0;
    o_awaddr        = '0;
    o_awlen         = '0;
    o_awvalid       = 1'b0;
    o_wdata         = '0;
    o_wlast         = 1'b0;
    o_wvalid        = 1'b0;
    o_bready        = 1'b0;
    o_araddr        = '0;
    o_arlen         = '0;
    o_arvalid       = 1'b0;
    o_rready        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_miss_req)
          w_next = (i_victim_valid && i_victim_dirty) ? S_AW : S_AR;
      end
      S_AW: begin
        o_awvalid = 1'b1;
        o_awaddr  = {r_vtag, w_set, {LINE_WIDTH{1'b0}}};
        o_awlen   = LEN;
        if (i_awready) begin
          w_next     = S_W;
          w_cnt_next = '0;
        end
      end
      S_W: begin
        o_wvalid     = 1'b1;
        o_line_index = r_cnt;
        o_wdata      = i_victim_data;
        o_wlast      = w_last;
        if (i_wready) begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_last) w_next = S_B;
        end
      end
      S_B: begin
        o_bready = 1'b1;
        if (i_bvalid) w_next = S_AR;
      end
      S_AR: begin
        o_arvalid = 1'b1;
        o_araddr  = {w_tag, w_set, {LINE_WIDTH{1'b0}}};
        o_arlen   = LEN;
        if (i_arready) begin
          w_next     = S_R;
          w_cnt_next = '0;
        end
      end
      S_R: begin
        o_rready     = 1'b1;
        o_line_index = r_cnt;
        if (i_rvalid) begin
          o_line_write_en = 1'b1;
          o_line_wdata    = i_rdata;
          o_line_valid    = 1'b1;
          o_line_tag      = w_tag;
          w_cnt_next      = r_cnt + 1'b1;
          if (w_last) w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
